alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, registered successor of the 8-bit datapath ALU, with a valid/ready handshake
//  on input and output. Adds status flags (Z,N,C,V), rotates, correct signed ASR, and a
//  multi-cycle MUL (full 2*WIDTH product). Sits between the register-file read stage and writeback.
// PARAMETERS
//  WIDTH   8  operand/result width, >=4, power of two
//  SHW     $clog2(WIDTH)  shift-amount bits used for rotates (derived, not overridden)
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  in_valid      in   1      operation offered
//  in_ready      out  1      operation accepted when in_valid & in_ready at clk edge
//  in_op         in   4      opcode: ADD=0 SUB=1 AND=2 OR=3 XOR=4 NOT=5 LSL=6 LSR=7 ASR=8 MUL=9 ROL=A ROR=B
//  in_a, in_b    in   WIDTH  operands (shift/rotate: a=data, b=amount, unsigned)
//  out_valid     out  1      result held until out_valid & out_ready
//  out_ready     in   1      consumer accepts result
//  out_result    out  WIDTH  result (MUL: low half)
//  out_result_hi out  WIDTH  MUL high half, 0 for all other ops
//  out_flags     out  4      {Z,N,C,V} of out_result
//  out_err       out  1      illegal opcode (C..F) was issued
// BEHAVIOUR
//  Reset: all outputs 0, except in_ready=1 once rst_n high; FSM->IDLE, MUL counter cleared.
//  in_ready = (state==IDLE) & (!out_valid | out_ready); drain and accept in the same cycle allowed.
//  FSM: IDLE --accept non-MUL--> IDLE (result regs loaded same edge, latency 1, throughput 1/clk)
//       IDLE --accept MUL--> MUL; MUL: WIDTH shift-add steps, one per clk; the last step loads
//       output regs and returns to IDLE. out_valid rises WIDTH edges after accept edge; in_ready=0 in MUL.
//  Output regs stay stable while out_valid & !out_ready. Output reg is always empty at MUL completion
//   (accept required it free or draining), so completion never stalls.
//  Arithmetic (all unsigned mod 2^WIDTH unless stated):
//   ADD: C=carry out; V=signed overflow (same-sign inputs, result sign differs)
//   SUB: a-b; C=borrow (a<b unsigned); V=signed overflow (a,b sign differ, result sign != a)
//   AND/OR/XOR/NOT(~a): C=V=0
//   LSL/LSR: b>=WIDTH -> 0; C=last bit shifted out (0 if b==0; 0 if b>WIDTH)
//   ASR: signed; b>=WIDTH -> all bits = a[MSB]; C=last bit out (b>=WIDTH -> a[MSB]; 0 if b==0)
//   ROL/ROR: amount = b mod WIDTH; C=V=0
//   MUL: unsigned a*b; C=V=(hi!=0)
//   Z=(out_result==0), N=out_result[MSB], for every legal op.
//  Illegal op: accepted like 1-cycle op; result=0, hi=0, flags=0, out_err=1 (out_err=0 otherwise).
//  rst_n low at any time (incl. mid-MUL): everything cleared immediately; in-flight op lost.
//  Operands latched at accept; in_a/in_b may change during MUL without effect.
// STRUCTURE
//  Package alu_pkg: opcode localparams, flag bit indices (FLG_Z=3,FLG_N=2,FLG_C=1,FLG_V=0),
//   state encoding (IDLE, MUL).
//  Sub-module alu_mul_seq: shift-add multiplier (start, a, b -> done, {hi,lo}); owns the step
//   counter and partial-product regs. Top holds the FSM, the combinational single-cycle datapath
//   and the output register.
// TESTING (WIDTH=8)
//  1 ADD 0x7F+0x01 -> 0x80, flags Z0 N1 C0 V1, out_valid 1 clk after accept
//  2 SUB 0x00-0x01 -> 0xFF, C1 N1 V0; SUB 0x80-0x01 -> 0x7F, V1 C0
//  3 ASR 0x80>>3 -> 0xF0 C0; LSR 0x80 by 9 -> 0x00 Z1; ROL 0x81 by 9 -> 0x03; LSL 0x81 by 1 -> 0x02 C1
//  4 MUL 0xFF*0xFF -> lo 0x01 hi 0xFE, C1 V1; out_valid exactly 8 clks after accept, in_ready=0 meanwhile
//  5 out_ready=0, two back-to-back ADDs -> 2nd held off, 1st result stable; out_ready=1 -> 1 op/clk streaming
//  6 rst_n low at MUL step 4 -> out_valid=0 at once; after release in_ready=1; op 0xC -> result 0, out_err=1

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Contents: opcode encodings, flag bit positions within out_flags, FSM state encoding.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_AND = 4'h2;
  localparam logic [OP_W-1:0] OP_OR  = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR = 4'h4;
  localparam logic [OP_W-1:0] OP_NOT = 4'h5;
  localparam logic [OP_W-1:0] OP_LSL = 4'h6;
  localparam logic [OP_W-1:0] OP_LSR = 4'h7;
  localparam logic [OP_W-1:0] OP_ASR = 4'h8;
  localparam logic [OP_W-1:0] OP_MUL = 4'h9;
  localparam logic [OP_W-1:0] OP_ROL = 4'hA;
  localparam logic [OP_W-1:0] OP_ROR = 4'hB;

  localparam int unsigned FLG_W = 4;
  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Handshake bus between the register-read stage, the ALU and writeback.
// Request side : in_valid/in_ready, in_op, in_a, in_b
// Response side: out_valid/out_ready, out_result, out_result_hi, out_flags, out_err
// master = producer of operations / consumer of results, slave = the ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_result_hi;
  logic [3:0]       out_flags;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_result_hi, out_flags, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_result_hi, out_flags, out_err
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one step per clock, WIDTH steps per product.
// Ports: clk, rst_n; start_i loads a_i/b_i; done_c_o flags the final step cycle,
// during which prod_c_o carries the complete {hi,lo} product (combinational).
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_c_o,
  output logic [2*WIDTH-1:0] prod_c_o
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic               busy_q;
  logic [SHW-1:0]     cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     sum_c;
  logic [2*WIDTH-1:0] step_c;

  // Upper half accumulates the multiplicand when the current multiplier LSB is set,
  // then the whole {carry,hi,lo} shifts right; lo starts as the multiplier.
  always_comb begin
    sum_c  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    step_c = {sum_c, prod_q[WIDTH-1:1]};
  end

  assign done_c_o = busy_q && (cnt_q == SHW'(WIDTH - 1));
  assign prod_c_o = step_c;

  // Step counter and partial product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      mcand_q <= a_i;
      prod_q  <= {{WIDTH{1'b0}}, b_i};
    end else if (busy_q) begin
      prod_q <= step_c;
      cnt_q  <= cnt_q + SHW'(1);
      if (done_c_o) begin
        busy_q <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, status flags and multi-cycle MUL.
// Ports: clk, rst_n (async, active-low); bus_if (slave) carries the request
// (in_valid/in_ready/in_op/in_a/in_b) and the held result
// (out_valid/out_ready/out_result/out_result_hi/out_flags/out_err).
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus_if
);
  localparam int unsigned     SHW     = $clog2(WIDTH);
  localparam int unsigned     MSB     = WIDTH - 1;
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [FLG_W-1:0]   flags_q, flags_d;
  logic               err_q, err_d;

  logic               in_ready_c;
  logic               accept_c;
  logic               mul_start_c;
  logic               mul_done_c;
  logic [2*WIDTH-1:0] mul_prod_c;

  logic [WIDTH-1:0]   a_c, b_c;
  logic [WIDTH-1:0]   alu_res_c;
  logic               alu_c_c, alu_v_c, alu_err_c;
  logic [WIDTH:0]     add_c, lsl_c, lsr_c;
  logic signed [WIDTH:0] asr_ext_c, asr_c;
  logic [2*WIDTH-1:0] rol_c, ror_c;
  logic [SHW-1:0]     rot_amt_c;

  assign in_ready_c = (state_q == ST_IDLE) && (!valid_q || bus_if.out_ready);
  assign accept_c   = bus_if.in_valid && in_ready_c;
  assign a_c        = bus_if.in_a;
  assign b_c        = bus_if.in_b;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start_c),
    .a_i      (a_c),
    .b_i      (b_c),
    .done_c_o (mul_done_c),
    .prod_c_o (mul_prod_c)
  );

  // Single-cycle datapath. Shifts carry one extra bit so the last bit shifted
  // out lands in the spare position; amount==WIDTH falls out naturally.
  always_comb begin
    alu_res_c = '0;
    alu_c_c   = 1'b0;
    alu_v_c   = 1'b0;
    alu_err_c = 1'b0;
    add_c     = {1'b0, a_c} + {1'b0, b_c};
    lsl_c     = {1'b0, a_c} << b_c;
    lsr_c     = {a_c, 1'b0} >> b_c;
    asr_ext_c = {a_c, 1'b0};
    asr_c     = asr_ext_c >>> b_c;
    rot_amt_c = b_c[SHW-1:0];
    rol_c     = {a_c, a_c} << rot_amt_c;
    ror_c     = {a_c, a_c} >> rot_amt_c;
    case (bus_if.in_op)
      OP_ADD: begin
        alu_res_c = add_c[WIDTH-1:0];
        alu_c_c   = add_c[WIDTH];
        alu_v_c   = (a_c[MSB] == b_c[MSB]) && (add_c[MSB] != a_c[MSB]);
      end
      OP_SUB: begin
        alu_res_c = a_c - b_c;
        alu_c_c   = a_c < b_c;
        alu_v_c   = (a_c[MSB] != b_c[MSB]) && (alu_res_c[MSB] != a_c[MSB]);
      end
      OP_AND: alu_res_c = a_c & b_c;
      OP_OR:  alu_res_c = a_c | b_c;
      OP_XOR: alu_res_c = a_c ^ b_c;
      OP_NOT: alu_res_c = ~a_c;
      OP_LSL: begin
        if (b_c <= WIDTH_V) {alu_c_c, alu_res_c} = lsl_c;
      end
      OP_LSR: begin
        if (b_c <= WIDTH_V) {alu_res_c, alu_c_c} = lsr_c;
      end
      OP_ASR: begin
        if (b_c >= WIDTH_V) begin
          alu_res_c = {WIDTH{a_c[MSB]}};
          alu_c_c   = a_c[MSB];
        end else begin
          {alu_res_c, alu_c_c} = asr_c;
        end
      end
      OP_ROL: alu_res_c = rol_c[2*WIDTH-1:WIDTH];
      OP_ROR: alu_res_c = ror_c[WIDTH-1:0];
      OP_MUL: alu_res_c = '0;
      default: alu_err_c = 1'b1;
    endcase
  end

  // FSM next state and output register loads
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q && !bus_if.out_ready;
    res_d       = res_q;
    hi_d        = hi_q;
    flags_d     = flags_q;
    err_d       = err_q;
    mul_start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (bus_if.in_op == OP_MUL) begin
            mul_start_c = 1'b1;
            state_d     = ST_MUL;
          end else begin
            valid_d = 1'b1;
            res_d   = alu_res_c;
            hi_d    = '0;
            err_d   = alu_err_c;
            flags_d = '0;
            if (!alu_err_c) begin
              flags_d[FLG_Z] = (alu_res_c == '0);
              flags_d[FLG_N] = alu_res_c[MSB];
              flags_d[FLG_C] = alu_c_c;
              flags_d[FLG_V] = alu_v_c;
            end
          end
        end
      end
      ST_MUL: begin
        // Output reg is guaranteed free here, so completion never stalls.
        if (mul_done_c) begin
          state_d        = ST_IDLE;
          valid_d        = 1'b1;
          res_d          = mul_prod_c[WIDTH-1:0];
          hi_d           = mul_prod_c[2*WIDTH-1:WIDTH];
          err_d          = 1'b0;
          flags_d        = '0;
          flags_d[FLG_Z] = (mul_prod_c[WIDTH-1:0] == '0);
          flags_d[FLG_N] = mul_prod_c[MSB];
          flags_d[FLG_C] = (mul_prod_c[2*WIDTH-1:WIDTH] != '0);
          flags_d[FLG_V] = (mul_prod_c[2*WIDTH-1:WIDTH] != '0);
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign bus_if.in_ready      = in_ready_c;
  assign bus_if.out_valid     = valid_q;
  assign bus_if.out_result    = res_q;
  assign bus_if.out_result_hi = hi_q;
  assign bus_if.out_flags     = flags_q;
  assign bus_if.out_err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8)) alu_if ();

  alu_seq #(.WIDTH(8)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (alu_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] res, input logic [7:0] hi,
                            input logic [3:0] fl, input logic err);
    chk({tag, ".valid"}, 32'(alu_if.out_valid), 32'(1'b1));
    chk({tag, ".res"},   32'(alu_if.out_result), 32'(res));
    chk({tag, ".hi"},    32'(alu_if.out_result_hi), 32'(hi));
    chk({tag, ".flags"}, 32'(alu_if.out_flags), 32'(fl));
    chk({tag, ".err"},   32'(alu_if.out_err), 32'(err));
  endtask

  // Present one op for one edge; returns #1 after that edge with in_valid dropped.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    alu_if.in_valid = 1'b1;
    alu_if.in_op    = op;
    alu_if.in_a     = a;
    alu_if.in_b     = b;
    @(posedge clk);
    #1;
    alu_if.in_valid = 1'b0;
  endtask

  // MUL: result must appear exactly 8 edges after accept, with in_ready low meanwhile.
  task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] lo, input logic [7:0] hi, input logic [3:0] fl);
    int early;
    early = 0;
    issue(OP_MUL, a, b);
    alu_if.in_a = 8'h5A;
    alu_if.in_b = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      if (alu_if.out_valid || alu_if.in_ready) early++;
      @(posedge clk);
      #1;
    end
    chk({tag, ".busy"}, 32'(early), 32'(0));
    expect_out(tag, lo, hi, fl, 1'b0);
  endtask

  initial begin
    int stale;
    alu_if.in_valid  = 1'b0;
    alu_if.in_op     = 4'h0;
    alu_if.in_a      = 8'h00;
    alu_if.in_b      = 8'h00;
    alu_if.out_ready = 1'b1;
    rst_n            = 1'b0;
    #12;
    chk("rst.valid", 32'(alu_if.out_valid), 32'(0));
    chk("rst.res",   32'(alu_if.out_result), 32'(0));
    chk("rst.hi",    32'(alu_if.out_result_hi), 32'(0));
    chk("rst.flags", 32'(alu_if.out_flags), 32'(0));
    chk("rst.err",   32'(alu_if.out_err), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.ready", 32'(alu_if.in_ready), 32'(1));

    // Arithmetic and flags
    issue(OP_ADD, 8'h7F, 8'h01); expect_out("add_ovf",  8'h80, 8'h00, 4'b0101, 1'b0);
    issue(OP_SUB, 8'h00, 8'h01); expect_out("sub_brw",  8'hFF, 8'h00, 4'b0110, 1'b0);
    issue(OP_SUB, 8'h80, 8'h01); expect_out("sub_ovf",  8'h7F, 8'h00, 4'b0001, 1'b0);
    issue(OP_XOR, 8'hFF, 8'hFF); expect_out("xor_z",    8'h00, 8'h00, 4'b1000, 1'b0);
    issue(OP_NOT, 8'h0F, 8'h33); expect_out("not",      8'hF0, 8'h00, 4'b0100, 1'b0);

    // Shifts and rotates, including amount 0, WIDTH and >WIDTH
    issue(OP_ASR, 8'h80, 8'd3);  expect_out("asr3",     8'hF0, 8'h00, 4'b0100, 1'b0);
    issue(OP_ASR, 8'h80, 8'd8);  expect_out("asr8",     8'hFF, 8'h00, 4'b0110, 1'b0);
    issue(OP_LSR, 8'h80, 8'd9);  expect_out("lsr9",     8'h00, 8'h00, 4'b1000, 1'b0);
    issue(OP_LSR, 8'h80, 8'd8);  expect_out("lsr8",     8'h00, 8'h00, 4'b1010, 1'b0);
    issue(OP_ROL, 8'h81, 8'd9);  expect_out("rol9",     8'h03, 8'h00, 4'b0000, 1'b0);
    issue(OP_ROR, 8'h01, 8'd1);  expect_out("ror1",     8'h80, 8'h00, 4'b0100, 1'b0);
    issue(OP_LSL, 8'h81, 8'd1);  expect_out("lsl1",     8'h02, 8'h00, 4'b0010, 1'b0);
    issue(OP_LSL, 8'h81, 8'd0);  expect_out("lsl0",     8'h81, 8'h00, 4'b0100, 1'b0);

    // Multi-cycle multiply
    run_mul("mul_ff", 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0011);
    run_mul("mul_small", 8'h0F, 8'h03, 8'h2D, 8'h00, 4'b0000);
    @(posedge clk);
    #1;
    chk("drain.valid", 32'(alu_if.out_valid), 32'(0));

    // Backpressure: first result held, second op held off
    alu_if.out_ready = 1'b0;
    issue(OP_ADD, 8'h01, 8'h02); expect_out("bp1", 8'h03, 8'h00, 4'b0000, 1'b0);
    alu_if.in_valid = 1'b1;
    alu_if.in_op    = OP_ADD;
    alu_if.in_a     = 8'h10;
    alu_if.in_b     = 8'h20;
    #1;
    chk("bp.ready0", 32'(alu_if.in_ready), 32'(0));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("bp.hold", 32'(alu_if.out_result), 32'(8'h03));
    end
    alu_if.out_ready = 1'b1;
    #1;
    chk("bp.ready1", 32'(alu_if.in_ready), 32'(1));
    @(posedge clk);
    #1;
    expect_out("bp2", 8'h30, 8'h00, 4'b0000, 1'b0);

    // Streaming, one op per clock
    for (int i = 1; i <= 3; i++) begin
      alu_if.in_a = 8'(i);
      alu_if.in_b = 8'(i);
      @(posedge clk);
      #1;
      chk("stream.res", 32'(alu_if.out_result), 32'(2 * i));
    end
    alu_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stream.end", 32'(alu_if.out_valid), 32'(0));

    // Reset during MUL step 4
    issue(OP_MUL, 8'h12, 8'h34);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst.valid", 32'(alu_if.out_valid), 32'(0));
    chk("mrst.ready", 32'(alu_if.in_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (alu_if.out_valid) stale++;
    end
    chk("mrst.stale", 32'(stale), 32'(0));
    chk("mrst.ready2", 32'(alu_if.in_ready), 32'(1));

    // Illegal opcodes, then error clears on a legal op
    issue(4'hC, 8'h12, 8'h34);   expect_out("ill_c",   8'h00, 8'h00, 4'b0000, 1'b1);
    issue(4'hF, 8'hFF, 8'hFF);   expect_out("ill_f",   8'h00, 8'h00, 4'b0000, 1'b1);
    issue(OP_ADD, 8'h00, 8'h00); expect_out("add_z",   8'h00, 8'h00, 4'b1000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
